fetch_unit: RTL and testbench

- Instruction-fetch sequencer sitting directly downstream of the 16-bit PC register (ld/inc register).
- Reads the current PC, issues a read request to instruction memory, and captures the returned word into an instruction register (IR) for decode.
- Drives the PC register's inc/ld/D inputs: increment after each fetch, load on branch redirect.
- Single IR slot; decode consumes through a valid/ready handshake.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: default bus widths and the fetch sequencer state encoding.
package fetch_unit_pkg;

  localparam int unsigned FETCH_AW = 16;
  localparam int unsigned FETCH_DW = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: requests the word at pc, captures it into a single IR slot,
// and steers the PC register (increment after capture, load on redirect).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned AW = FETCH_AW,
  parameter int unsigned DW = FETCH_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic [AW-1:0] pc_d,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt
);

  fetch_state_e  state_q, state_n;
  logic [DW-1:0] ir_n;
  logic [AW-1:0] ir_pc_n;
  logic          ir_valid_n;

  // State and IR slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state_q  <= state_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

  // Next state, IR capture and PC-register / memory control.
  always_comb begin
    state_n    = state_q;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    pc_inc     = 1'b0;
    pc_ld      = redirect;
    pc_d       = redirect_pc;
    mem_addr   = pc;
    mem_req    = (state_q == S_REQ) && !halt;

    // A redirect squashes any held instruction, including one being accepted this cycle.
    if (redirect) begin
      ir_valid_n = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (mem_req && mem_gnt) begin
          state_n = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_n = mem_rvalid ? S_REQ : S_DROP;
        end else if (mem_rvalid) begin
          ir_n       = mem_rdata;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          pc_inc     = 1'b1;
          state_n    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_n = S_REQ;
        end else if (ir_ready) begin
          ir_valid_n = 1'b0;
          state_n    = S_REQ;
        end
      end
      S_DROP: begin
        if (mem_rvalid) begin
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked every cycle against
// a transaction-level model (outstanding read / discard / IR-full flags) plus a PC register.
module tb_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          pc_inc, pc_ld;
  logic [AW-1:0] pc_d;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid, ir_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;

  always #5 clk = ~clk;

  fetch_unit #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: is a read in flight, must its data be thrown away, is the IR slot full.
  bit            m_busy, m_discard, m_full;
  logic [DW-1:0] m_ir;
  logic [AW-1:0] m_ir_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: check all outputs against the model, then advance model and PC register.
  task automatic tick();
    bit            exp_req, exp_inc, nb, nd, nf, s_inc, s_ld;
    logic [DW-1:0] nir;
    logic [AW-1:0] nirpc, npc;
    #1;
    exp_req = !m_busy && !m_full && !halt;
    exp_inc = m_busy && !m_discard && mem_rvalid && !redirect;
    chk("mem_req",  32'(mem_req),  32'(exp_req));
    chk("mem_addr", 32'(mem_addr), 32'(pc));
    chk("pc_inc",   32'(pc_inc),   32'(exp_inc));
    chk("pc_ld",    32'(pc_ld),    32'(redirect));
    chk("pc_d",     32'(pc_d),     32'(redirect_pc));
    chk("ir",       32'(ir),       32'(m_ir));
    chk("ir_pc",    32'(ir_pc),    32'(m_ir_pc));
    chk("ir_valid", 32'(ir_valid), 32'(m_full));

    nb = m_busy; nd = m_discard; nf = m_full; nir = m_ir; nirpc = m_ir_pc;
    if (reset) begin
      nb = 0; nd = 0; nf = 0; nir = '0; nirpc = '0;
    end else if (redirect) begin
      nf = 0;
      if (m_busy) begin
        if (mem_rvalid) begin nb = 0; nd = 0; end
        else nd = 1;
      end else if (exp_req && mem_gnt) begin
        nb = 1; nd = 1;
      end
    end else begin
      if (m_busy && mem_rvalid) begin
        nb = 0; nd = 0;
        if (!m_discard) begin nf = 1; nir = mem_rdata; nirpc = pc; end
      end else if (exp_req && mem_gnt) begin
        nb = 1; nd = 0;
      end
      if (m_full && ir_ready) nf = 0;
    end

    s_inc = pc_inc; s_ld = pc_ld;
    npc = pc;
    if (s_ld && !s_inc) npc = redirect_pc;
    else if (s_inc && !s_ld) npc = pc + 16'd1;

    @(posedge clk);
    #1;
    m_busy = nb; m_discard = nd; m_full = nf; m_ir = nir; m_ir_pc = nirpc; pc = npc;
  endtask

  initial begin
    reset = 1; pc = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; ir_ready = 0;
    redirect = 0; redirect_pc = '0; halt = 0;
    m_busy = 0; m_discard = 0; m_full = 0; m_ir = '0; m_ir_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset ir_valid", 32'(ir_valid), 32'd0);
    chk("reset ir",       32'(ir),       32'd0);

    // Basic fetch from 0x0000, zero-wait memory.
    reset = 0; pc = 16'h0000; mem_gnt = 1; ir_ready = 1;
    #1 chk("t1 req c0", 32'(mem_req), 32'd1);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'hA123;
    #1 chk("t1 inc c1", 32'(pc_inc), 32'd1);
    tick();
    mem_rvalid = 0;
    chk("t1 ir",       32'(ir),       32'h0000A123);
    chk("t1 ir_pc",    32'(ir_pc),    32'h0);
    chk("t1 ir_valid", 32'(ir_valid), 32'd1);
    tick();
    #1 chk("t1 req c3",  32'(mem_req),  32'd1);
    chk("t1 addr c3",    32'(mem_addr), 32'h0001);

    // Decode stall for 5 cycles in S_HOLD.
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h5A5A; tick();
    mem_rvalid = 0; ir_ready = 0;
    repeat (5) begin
      #1 chk("t2 stall valid", 32'(ir_valid), 32'd1);
      chk("t2 stall req", 32'(mem_req), 32'd0);
      chk("t2 stall pc",  32'(mem_addr), 32'h0002);
      tick();
    end
    ir_ready = 1; tick();
    #1 chk("t2 release valid", 32'(ir_valid), 32'd0);
    chk("t2 release req", 32'(mem_req), 32'd1);

    // Redirect while waiting; late response must be dropped.
    mem_gnt = 1; tick();
    mem_gnt = 0; redirect = 1; redirect_pc = 16'h0040;
    #1 chk("t3 ld", 32'(pc_ld), 32'd1);
    chk("t3 inc", 32'(pc_inc), 32'd0);
    tick();
    redirect = 0; tick();
    mem_rvalid = 1; mem_rdata = 16'hDEAD;
    #1 chk("t3 drop inc", 32'(pc_inc), 32'd0);
    tick();
    mem_rvalid = 0;
    #1 chk("t3 ir kept", 32'(ir), 32'h00005A5A);
    chk("t3 addr", 32'(mem_addr), 32'h0040);
    chk("t3 req",  32'(mem_req),  32'd1);

    // Redirect coincident with rvalid in S_WAIT.
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'hBEEF; redirect = 1; redirect_pc = 16'h0100;
    #1 chk("t4 inc", 32'(pc_inc), 32'd0);
    chk("t4 ld", 32'(pc_ld), 32'd1);
    tick();
    mem_rvalid = 0; redirect = 0;
    #1 chk("t4 ir kept", 32'(ir), 32'h00005A5A);
    chk("t4 valid", 32'(ir_valid), 32'd0);
    chk("t4 addr",  32'(mem_addr), 32'h0100);
    chk("t4 req",   32'(mem_req),  32'd1);

    // Fetch at 0xFFFF; PC wraps to 0x0000.
    redirect = 1; redirect_pc = 16'hFFFF; tick();
    redirect = 0; mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h1234; tick();
    mem_rvalid = 0;
    chk("t5 ir_pc", 32'(ir_pc), 32'h0000FFFF);
    tick();
    #1 chk("t5 wrap addr", 32'(mem_addr), 32'h0000);

    // Halt gates requests, then reset lands mid-wait.
    halt = 1; mem_gnt = 1;
    repeat (4) begin
      #1 chk("t6 halt req", 32'(mem_req), 32'd0);
      tick();
    end
    halt = 0; tick();
    mem_gnt = 0; reset = 1; tick();
    reset = 0; halt = 1;
    #1 chk("t6 rst valid", 32'(ir_valid), 32'd0);
    chk("t6 rst ir", 32'(ir), 32'd0);
    chk("t6 rst req halted", 32'(mem_req), 32'd0);
    tick();
    halt = 0;
    #1 chk("t6 rst req", 32'(mem_req), 32'd1);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      halt        = ($urandom_range(0, 7) == 0);
      mem_gnt     = $urandom_range(0, 1) == 1;
      mem_rvalid  = m_busy ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 9) == 0);
      mem_rdata   = DW'($urandom);
      ir_ready    = $urandom_range(0, 1) == 1;
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = AW'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
